// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target responder backed by a small 8-bit register file.
// SCL/SDA are synchronized and glitch-filtered in the aclk domain; SDA is driven
// open-drain through an external IOBUF (sda_o fixed 0, sda_t selects pull-low).
// Ports:
//   aclk, aresetn      fabric clock, synchronous active-low reset
//   scl_i, sda_i       asynchronous pad inputs
//   sda_o, sda_t       SDA pad drive value / tristate (1 = released)
//   loc_addr/loc_rdata local read port, 1-cycle registered latency
//   wr_strobe/addr/data one-cycle notification of each byte written by the master
//   busy               high from an accepted START until STOP
module i2c_target_regfile #(
  parameter logic [6:0]  DEV_ADDR = 7'h50,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned FILT_CYC = 3
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        scl_i,
  input  logic                        sda_i,
  output logic                        sda_o,
  output logic                        sda_t,
  input  logic [$clog2(NUM_REGS)-1:0] loc_addr,
  output logic [7:0]                  loc_rdata,
  output logic                        wr_strobe,
  output logic [$clog2(NUM_REGS)-1:0] wr_addr,
  output logic [7:0]                  wr_data,
  output logic                        busy
);

  localparam int unsigned AW = $clog2(NUM_REGS);
  localparam int unsigned CW = $clog2(FILT_CYC) + 1;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_e;

  // Index 0 = SCL, index 1 = SDA. Bus idles high, so conditioning resets to 1.
  logic [1:0]    s1_q, s2_q, f_q, fp_q;
  logic [CW-1:0] cnt_q [2];

  // 2-FF synchronizer followed by a stability filter: a new level is accepted
  // only after it has been seen for FILT_CYC consecutive cycles.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s1_q <= 2'b11;
      s2_q <= 2'b11;
      f_q  <= 2'b11;
      fp_q <= 2'b11;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= {sda_i, scl_i};
      s2_q <= s1_q;
      fp_q <= f_q;
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == f_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CW'(FILT_CYC - 1)) begin
          f_q[i]   <= s2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  logic       scl_f, sda_f, scl_rise_c, scl_fall_c, start_c, stop_c, last_bit_c;
  logic [7:0] byte_c;

  assign scl_f      = f_q[0];
  assign sda_f      = f_q[1];
  assign scl_rise_c = scl_f & ~fp_q[0];
  assign scl_fall_c = ~scl_f & fp_q[0];
  // SCL must be high both before and after the SDA edge, so SDA moves during SCL low never qualify.
  assign start_c    = scl_f & fp_q[0] & fp_q[1] & ~sda_f;
  assign stop_c     = scl_f & fp_q[0] & ~fp_q[1] & sda_f;

  state_e         state_q;
  logic [2:0]     bit_cnt_q;
  logic [7:0]     shift_q;
  logic [1:0]     ph_q;     // phase within an ACK slot
  logic           rw_q;
  logic [AW-1:0]  ptr_q;
  logic [7:0]     regs_q [NUM_REGS];

  assign byte_c     = {shift_q[6:0], sda_f};
  assign last_bit_c = (bit_cnt_q == 3'd7);
  assign sda_o      = 1'b0;

  // Protocol FSM, register file and registered outputs.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ph_q      <= '0;
      rw_q      <= 1'b0;
      ptr_q     <= '0;
      sda_t     <= 1'b1;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      loc_rdata <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[AW'(i)] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      loc_rdata <= regs_q[loc_addr];
      if (start_c) begin
        // Also covers repeated START; the pointer is kept on purpose.
        state_q   <= ADDR;
        bit_cnt_q <= '0;
        sda_t     <= 1'b1;
        busy      <= 1'b1;
      end else if (stop_c) begin
        state_q <= IDLE;
        sda_t   <= 1'b1;
        busy    <= 1'b0;
      end else begin
        case (state_q)
          ADDR, PTR, WDATA: begin
            if (scl_rise_c) begin
              shift_q   <= byte_c;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (last_bit_c) begin
                ph_q <= 2'd0;
                case (state_q)
                  ADDR: begin
                    rw_q    <= sda_f;
                    state_q <= (shift_q[6:0] == DEV_ADDR) ? ADDR_ACK : IGNORE;
                  end
                  PTR: begin
                    ptr_q   <= AW'(byte_c);
                    state_q <= PTR_ACK;
                  end
                  default: begin
                    regs_q[ptr_q] <= byte_c;
                    wr_strobe     <= 1'b1;
                    wr_addr       <= ptr_q;
                    wr_data       <= byte_c;
                    ptr_q         <= ptr_q + AW'(1);
                    state_q       <= WDATA_ACK;
                  end
                endcase
              end
            end
          end
          // First SCL fall pulls SDA low for the ACK clock, second fall ends it.
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            if (scl_fall_c) begin
              if (ph_q == 2'd0) begin
                sda_t <= 1'b0;
                ph_q  <= 2'd1;
              end else begin
                bit_cnt_q <= '0;
                if (state_q == ADDR_ACK && rw_q) begin
                  sda_t   <= regs_q[ptr_q][7];
                  shift_q <= {regs_q[ptr_q][6:0], 1'b0};
                  state_q <= RDATA;
                end else begin
                  sda_t   <= 1'b1;
                  state_q <= (state_q == ADDR_ACK) ? PTR : WDATA;
                end
              end
            end
          end
          // shift_q[7] always holds the next bit to present after an SCL fall.
          RDATA: begin
            if (scl_rise_c) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (last_bit_c) begin
                state_q <= RDATA_ACK;
                ph_q    <= 2'd0;
              end
            end
            if (scl_fall_c) begin
              sda_t   <= shift_q[7];
              shift_q <= {shift_q[6:0], 1'b0};
            end
          end
          RDATA_ACK: begin
            if (scl_fall_c && ph_q == 2'd0) begin
              sda_t <= 1'b1;
              ph_q  <= 2'd1;
            end else if (scl_rise_c && ph_q == 2'd1) begin
              ptr_q <= ptr_q + AW'(1);
              if (sda_f) state_q <= IGNORE;
              else       ph_q    <= 2'd2;
            end else if (scl_fall_c && ph_q == 2'd2) begin
              sda_t     <= regs_q[ptr_q][7];
              shift_q   <= {regs_q[ptr_q][6:0], 1'b0};
              bit_cnt_q <= '0;
              state_q   <= RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed testbench for i2c_target_regfile: a task-driven I2C master on an
// open-drain SDA model, plus a monitor that records write strobes.
module tb_i2c_target_regfile;

  localparam int Q = 10; // aclk cycles per SCL quarter-phase

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [3:0] loc_addr = 4'd0;
  logic       sda_o, sda_t, wr_strobe, busy;
  logic [7:0] loc_rdata, wr_data;
  logic [3:0] wr_addr;
  logic       sda_bus;

  int errors = 0;
  int checks = 0;

  assign sda_bus = sda_m & (sda_t | sda_o);

  i2c_target_regfile #(.DEV_ADDR(7'h50), .NUM_REGS(16), .FILT_CYC(3)) dut (
    .aclk(aclk), .aresetn(aresetn), .scl_i(scl_m), .sda_i(sda_bus),
    .sda_o(sda_o), .sda_t(sda_t), .loc_addr(loc_addr), .loc_rdata(loc_rdata),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 aclk = ~aclk;

  // Monitor: log strobes, count over-wide strobes and cycles with SDA pulled low.
  int   wa_q[$];
  int   wd_q[$];
  int   low_cnt = 0;
  int   wide_cnt = 0;
  logic strobe_prev = 1'b0;
  always @(negedge aclk) begin
    if (wr_strobe) begin
      wa_q.push_back(int'(wr_addr));
      wd_q.push_back(int'(wr_data));
    end
    if (wr_strobe && strobe_prev) wide_cnt++;
    strobe_prev = wr_strobe;
    if (!sda_t) low_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    b = sda_bus; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    tick(3);
    checks++; if (sda_t !== 1'b1) begin errors++; $display("FAIL rst_sda_t: got %b want 1", sda_t); end
    checks++; if (sda_o !== 1'b0) begin errors++; $display("FAIL rst_sda_o: got %b want 0", sda_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL rst_wr_strobe: got %b want 0", wr_strobe); end
    checks++; if (wr_addr !== 4'd0) begin errors++; $display("FAIL rst_wr_addr: got %h want 0", wr_addr); end
    checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL rst_wr_data: got %h want 00", wr_data); end
    checks++; if (loc_rdata !== 8'h00) begin errors++; $display("FAIL rst_loc_rdata: got %h want 00", loc_rdata); end
    aresetn = 1'b1;
    tick(Q);
  endtask

  task automatic test_write_burst();
    logic a0, a1, a2, a3;
    int   base;
    base = wa_q.size();
    i2c_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wb_busy_start: got %b want 1", busy); end
    write_byte(8'hA0, a0);
    write_byte(8'h03, a1);
    write_byte(8'h11, a2);
    write_byte(8'h22, a3);
    checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("FAIL wb_acks: got %b want 0000", {a0, a1, a2, a3}); end
    i2c_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wb_busy_stop: got %b want 0", busy); end
    checks++; if (wa_q.size() - base !== 2) begin errors++; $display("FAIL wb_strobe_cnt: got %0d want 2", wa_q.size() - base); end
    if (wa_q.size() - base >= 2) begin
      checks++; if (wa_q[base] !== 3 || wd_q[base] !== 8'h11) begin errors++; $display("FAIL wb_strobe0: got (%0d,%h) want (3,11)", wa_q[base], wd_q[base]); end
      checks++; if (wa_q[base+1] !== 4 || wd_q[base+1] !== 8'h22) begin errors++; $display("FAIL wb_strobe1: got (%0d,%h) want (4,22)", wa_q[base+1], wd_q[base+1]); end
    end
    loc_addr = 4'd4; tick(2);
    checks++; if (loc_rdata !== 8'h22) begin errors++; $display("FAIL wb_loc4: got %h want 22", loc_rdata); end
    loc_addr = 4'd3; tick(2);
    checks++; if (loc_rdata !== 8'h11) begin errors++; $display("FAIL wb_loc3: got %h want 11", loc_rdata); end
  endtask

  task automatic test_random_read();
    logic       a0, a1, a2;
    logic [7:0] d0, d1;
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h03, a1);
    i2c_rstart();
    write_byte(8'hA1, a2);
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL rr_acks: got %b want 000", {a0, a1, a2}); end
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    checks++; if (d0 !== 8'h11) begin errors++; $display("FAIL rr_byte0: got %h want 11", d0); end
    checks++; if (d1 !== 8'h22) begin errors++; $display("FAIL rr_byte1: got %h want 22", d1); end
    checks++; if (sda_t !== 1'b1) begin errors++; $display("FAIL rr_release: got %b want 1", sda_t); end
    i2c_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy_stop: got %b want 0", busy); end
  endtask

  task automatic test_addr_mismatch();
    logic a0, a1;
    int   base, low0;
    base = wa_q.size();
    low0 = low_cnt;
    i2c_start();
    write_byte(8'hA2, a0);
    write_byte(8'h5C, a1);
    i2c_stop();
    checks++; if (a0 !== 1'b1) begin errors++; $display("FAIL am_addr_nack: got %b want 1", a0); end
    checks++; if (a1 !== 1'b1) begin errors++; $display("FAIL am_data_nack: got %b want 1", a1); end
    checks++; if (low_cnt - low0 !== 0) begin errors++; $display("FAIL am_sda_low: got %0d cycles want 0", low_cnt - low0); end
    checks++; if (wa_q.size() - base !== 0) begin errors++; $display("FAIL am_strobe: got %0d want 0", wa_q.size() - base); end
  endtask

  task automatic test_wraparound();
    logic a0, a1, a2, a3;
    int   base;
    base = wa_q.size();
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h1F, a1);
    write_byte(8'hAA, a2);
    write_byte(8'hBB, a3);
    i2c_stop();
    checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("FAIL wr_acks: got %b want 0000", {a0, a1, a2, a3}); end
    checks++; if (wa_q.size() - base !== 2) begin errors++; $display("FAIL wr_strobe_cnt: got %0d want 2", wa_q.size() - base); end
    if (wa_q.size() - base >= 2) begin
      checks++; if (wa_q[base] !== 15 || wa_q[base+1] !== 0) begin errors++; $display("FAIL wr_strobe_addr: got %0d,%0d want 15,0", wa_q[base], wa_q[base+1]); end
    end
    loc_addr = 4'd15; tick(2);
    checks++; if (loc_rdata !== 8'hAA) begin errors++; $display("FAIL wr_reg15: got %h want aa", loc_rdata); end
    loc_addr = 4'd0; tick(2);
    checks++; if (loc_rdata !== 8'hBB) begin errors++; $display("FAIL wr_reg0: got %h want bb", loc_rdata); end
    checks++; if (wide_cnt !== 0) begin errors++; $display("FAIL wr_strobe_width: got %0d wide pulses want 0", wide_cnt); end
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1, a2, a3, a4, a5, b7;
    int   base;
    // reg0 = 0xBB: bit7 = 1, bit6 = 0, so the target pulls SDA low for bit 6.
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h00, a1);
    i2c_rstart();
    write_byte(8'hA1, a2);
    read_bit(b7);
    checks++; if ({a0, a1, a2, b7} !== 4'b0001) begin errors++; $display("FAIL rm_setup: got %b want 0001", {a0, a1, a2, b7}); end
    checks++; if (sda_t !== 1'b0) begin errors++; $display("FAIL rm_driving: got %b want 0", sda_t); end
    aresetn = 1'b0;
    tick(1);
    checks++; if (sda_t !== 1'b1) begin errors++; $display("FAIL rm_sda_release: got %b want 1", sda_t); end
    checks++; if (busy !== 1'b0 || wr_strobe !== 1'b0 || wr_addr !== 4'd0 || wr_data !== 8'h00 || loc_rdata !== 8'h00)
      begin errors++; $display("FAIL rm_outputs: got busy=%b strb=%b wa=%h wd=%h lr=%h want all 0", busy, wr_strobe, wr_addr, wr_data, loc_rdata); end
    tick(3);
    aresetn = 1'b1;
    tick(Q);
    base = wa_q.size();
    i2c_start();
    write_byte(8'hA0, a3);
    write_byte(8'h02, a4);
    write_byte(8'h5A, a5);
    i2c_stop();
    checks++; if ({a3, a4, a5} !== 3'b000) begin errors++; $display("FAIL rm_next_acks: got %b want 000", {a3, a4, a5}); end
    checks++; if (wa_q.size() - base !== 1) begin errors++; $display("FAIL rm_next_strobe: got %0d want 1", wa_q.size() - base); end
    loc_addr = 4'd2; tick(2);
    checks++; if (loc_rdata !== 8'h5A) begin errors++; $display("FAIL rm_reg2: got %h want 5a", loc_rdata); end
    loc_addr = 4'd15; tick(2);
    checks++; if (loc_rdata !== 8'h00) begin errors++; $display("FAIL rm_reg15_cleared: got %h want 00", loc_rdata); end
  endtask

  task automatic test_glitch();
    int busy_seen;
    busy_seen = 0;
    sda_m = 1'b0; tick(2);
    sda_m = 1'b1;
    for (int i = 0; i < 2 * Q; i++) begin
      tick(1);
      if (busy) busy_seen++;
    end
    checks++; if (busy_seen !== 0) begin errors++; $display("FAIL gl_short_pulse: got busy for %0d cycles want 0", busy_seen); end
    // A pulse comfortably longer than the filter must be accepted as START.
    sda_m = 1'b0; tick(Q);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gl_long_pulse_start: got %b want 1", busy); end
    sda_m = 1'b1; tick(Q);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gl_long_pulse_stop: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_random_read();
    test_addr_mismatch();
    test_wraparound();
    test_reset_mid_read();
    test_glitch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
